// File: rtl/y_fetch_seq_if.sv
// Fetch-sequencer bus: redirect/control inputs and PC/status outputs.
// Sequencer uses the slave modport; the driving pipeline uses master.
interface y_fetch_seq_if #(
  parameter int W  = 32,
  parameter int CW = 16
) ();
  logic [W-1:0]  entryPoint;
  logic          stall;
  logic          br_taken;
  logic [W-1:0]  br_target;
  logic          jump;
  logic [W-1:0]  jump_target;
  logic          call;
  logic          ret;
  logic          halt_req;
  logic          resume;
  logic [W-1:0]  pc;
  logic          pc_valid;
  logic [1:0]    state;
  logic [CW-1:0] ins_count;
  logic          ras_empty;
  logic          ras_full;
  logic          err;

  modport master (
    output entryPoint, stall, br_taken, br_target, jump, jump_target,
    output call, ret, halt_req, resume,
    input  pc, pc_valid, state, ins_count, ras_empty, ras_full, err
  );

  modport slave (
    input  entryPoint, stall, br_taken, br_target, jump, jump_target,
    input  call, ret, halt_req, resume,
    output pc, pc_valid, state, ins_count, ras_empty, ras_full, err
  );
endinterface

// File: rtl/y_fetch_seq.sv
// Instruction-fetch PC sequencer with RESET/RUN/HALT control and a circular
// return-address stack; the stack exists only when Y_FETCH_RAS_EN is defined.
module y_fetch_seq #(
  parameter int W         = 32,
  parameter int STEP      = 4,
  parameter int RAS_DEPTH = 4,
  parameter int CW        = 16
) (
  input logic        clk,
  input logic        INT,
  y_fetch_seq_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  state_t        state_r;
  logic [W-1:0]  pc_r;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  pc_seq_s;
  logic [W-1:0]  pc_next_s;
  logic          fetch_s;

  assign pc_seq_s = pc_r + W'(STEP);
  // A fetch retires only when the sequencer actually advances this cycle.
  assign fetch_s  = (state_r == ST_RUN) & ~bus.stall & ~bus.halt_req;

`ifdef Y_FETCH_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [W-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0] sp_r;
  logic [PW:0]   depth_r;
  logic          err_r;
  logic          push_s;
  logic          pop_s;
  logic          err_set_s;

  // Next-PC selection: ret > call > jump > branch > sequential.
  always_comb begin
    pc_next_s = pc_seq_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    if (bus.ret) begin
      if (depth_r != '0) begin
        pop_s     = 1'b1;
        pc_next_s = ras_mem_r[sp_r - PW'(1)];
      end else begin
        err_set_s = 1'b1;
        pc_next_s = bus.entryPoint;
      end
    end else if (bus.call) begin
      push_s    = 1'b1;
      pc_next_s = bus.jump_target;
    end else if (bus.jump) begin
      pc_next_s = bus.jump_target;
    end else if (bus.br_taken) begin
      pc_next_s = bus.br_target;
    end else begin
      pc_next_s = pc_seq_s;
    end
  end

  assign bus.ras_empty = (depth_r == '0);
  assign bus.ras_full  = (depth_r == (PW+1)'(RAS_DEPTH));
  assign bus.err       = err_r;
`else
  // Next-PC selection without a stack: call degrades to jump, ret is ignored.
  always_comb begin
    pc_next_s = pc_seq_s;
    if (bus.call | bus.jump) begin
      pc_next_s = bus.jump_target;
    end else if (bus.br_taken) begin
      pc_next_s = bus.br_target;
    end else begin
      pc_next_s = pc_seq_s;
    end
  end

  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.err       = 1'b0;
`endif

  // Sequencer FSM, PC, retire counter and return stack.
  always_ff @(posedge clk) begin
    if (INT) begin
      state_r <= ST_RESET;
      pc_r    <= bus.entryPoint;
      cnt_r   <= '0;
`ifdef Y_FETCH_RAS_EN
      sp_r    <= '0;
      depth_r <= '0;
      err_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_RESET: state_r <= ST_RUN;
        ST_RUN: begin
          if (bus.halt_req) begin
            state_r <= ST_HALT;
          end else if (!bus.stall) begin
            pc_r <= pc_next_s;
            if (cnt_r != {CW{1'b1}}) begin
              cnt_r <= cnt_r + CW'(1);
            end
`ifdef Y_FETCH_RAS_EN
            // Full stack keeps depth and silently overwrites the oldest slot.
            if (push_s) begin
              ras_mem_r[sp_r] <= pc_seq_s;
              sp_r            <= sp_r + PW'(1);
              if (depth_r != (PW+1)'(RAS_DEPTH)) begin
                depth_r <= depth_r + (PW+1)'(1);
              end
            end else if (pop_s) begin
              sp_r    <= sp_r - PW'(1);
              depth_r <= depth_r - (PW+1)'(1);
            end
            if (err_set_s) begin
              err_r <= 1'b1;
            end
`endif
          end
        end
        ST_HALT: begin
          if (bus.resume && !bus.halt_req) begin
            state_r <= ST_RUN;
          end
        end
        default: state_r <= ST_RESET;
      endcase
    end
  end

  assign bus.pc        = pc_r;
  assign bus.pc_valid  = fetch_s;
  assign bus.state     = state_r;
  assign bus.ins_count = cnt_r;
endmodule
